// File: rtl/gen_case_add_pkg.sv
// Shared constants and helpers for gen_case_adder: architecture selection
// thresholds and the lookahead group count.
package gen_case_add_pkg;

  localparam int RIPPLE_MAX_W = 4;
  localparam int CLA_GROUP_W  = 4;

  typedef enum logic [1:0] {
    ARCH_SINGLE,
    ARCH_RIPPLE,
    ARCH_CLA
  } adder_arch_e;

  function automatic int num_groups(input int n);
    return (n + CLA_GROUP_W - 1) / CLA_GROUP_W;
  endfunction

  function automatic adder_arch_e arch_for(input int n);
    if (n == 1)
      return ARCH_SINGLE;
    else if (n <= RIPPLE_MAX_W)
      return ARCH_RIPPLE;
    else
      return ARCH_CLA;
  endfunction

endpackage

// File: rtl/gen_case_adder_full_adder.sv
// One-bit full adder cell used by the single-bit and ripple-carry builds
// of gen_case_adder.
module full_adder (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/gen_case_adder.sv
// Width-configurable adder with one-cycle registered result; the carry
// structure is chosen from N. Define GEN_CASE_ADD_OVF_EN for a signed overflow output.
module gen_case_adder
  import gen_case_add_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] sum,
  output logic         carry_out,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         carry_in
`ifdef GEN_CASE_ADD_OVF_EN
  ,
  output logic         overflow
`endif
);

  localparam adder_arch_e ARCH = arch_for(N);

  // carry[i] is the carry into bit i; carry[N] is the final carry out
  logic [N:0]   carry;
  logic [N-1:0] sum_c;
  logic [N:0]   result;
  logic [N-1:0] sum_reg;
  logic         carry_out_reg;

  assign carry[0] = carry_in;

  generate
    case (ARCH)
      ARCH_SINGLE: begin : g_single
        full_adder u_fa (
          .s    (sum_c[0]),
          .cout (carry[1]),
          .a    (in1[0]),
          .b    (in2[0]),
          .cin  (carry[0])
        );
      end

      ARCH_RIPPLE: begin : g_ripple
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
          full_adder u_fa (
            .s    (sum_c[gi]),
            .cout (carry[gi+1]),
            .a    (in1[gi]),
            .b    (in2[gi]),
            .cin  (carry[gi])
          );
        end
      end

      default: begin : g_cla
        for (genvar gi = 0; gi < num_groups(N); gi++) begin : g_grp
          localparam int LO = gi * CLA_GROUP_W;
          localparam int GW = (N - LO < CLA_GROUP_W) ? (N - LO) : CLA_GROUP_W;

          logic [GW-1:0] p;
          logic [GW-1:0] g;
          // gpre[j]/ppre[j]: generate/propagate of bits 0..j of this group
          logic [GW-1:0] gpre;
          logic [GW-1:0] ppre;

          assign p = in1[LO+GW-1:LO] ^ in2[LO+GW-1:LO];
          assign g = in1[LO+GW-1:LO] & in2[LO+GW-1:LO];

          always_comb begin
            gpre = '0;
            ppre = '0;
            for (int j = 0; j < GW; j++) begin
              if (j == 0) begin
                gpre[j] = g[j];
                ppre[j] = p[j];
              end else begin
                gpre[j] = g[j] | (p[j] & gpre[j-1]);
                ppre[j] = p[j] & ppre[j-1];
              end
            end
          end

          for (genvar gj = 0; gj < GW - 1; gj++) begin : g_inner
            assign carry[LO+gj+1] = gpre[gj] | (ppre[gj] & carry[LO]);
          end

          // group P/G hand the carry on to the next group
          assign carry[LO+GW] = gpre[GW-1] | (ppre[GW-1] & carry[LO]);
          assign sum_c[LO+GW-1:LO] = p ^ carry[LO+GW-1:LO];
        end
      end
    endcase
  endgenerate

  assign result = {carry[N], sum_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      sum_reg       <= result[N-1:0];
      carry_out_reg <= result[N];
    end
  end

  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;

`ifdef GEN_CASE_ADD_OVF_EN
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (rst)
      overflow_reg <= 1'b0;
    else
      overflow_reg <= carry[N] ^ carry[N-1];
  end

  assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_gen_case_adder.sv
// Self-checking bench: several widths of gen_case_adder share one stimulus
// stream and are compared every cycle against an arithmetic reference.
module tb_gen_case_adder;

  localparam int NI = 7;
  localparam int WIDTHS [NI] = '{1, 3, 4, 5, 8, 16, 33};
  localparam int I_N1  = 0;
  localparam int I_N3  = 1;
  localparam int I_N5  = 3;
  localparam int I_N8  = 4;
  localparam int I_N16 = 5;
  localparam int I_N33 = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] a_vec = '0;
  logic [32:0] b_vec = '0;
  logic        cin = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [32:0] dut_sum  [NI];
  logic        dut_cout [NI];
`ifdef GEN_CASE_ADD_OVF_EN
  logic        dut_ovf  [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = WIDTHS[gi];
    logic [W-1:0] s;
    logic         co;
`ifdef GEN_CASE_ADD_OVF_EN
    logic         ov;
`endif
    gen_case_adder #(.N(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .sum       (s),
      .carry_out (co),
      .in1       (a_vec[W-1:0]),
      .in2       (b_vec[W-1:0]),
      .carry_in  (cin)
`ifdef GEN_CASE_ADD_OVF_EN
      ,
      .overflow  (ov)
`endif
    );
    assign dut_sum[gi]  = 33'(s);
    assign dut_cout[gi] = co;
`ifdef GEN_CASE_ADD_OVF_EN
    assign dut_ovf[gi]  = ov;
`endif
  end

  // Reference: plain integer add for sum/carry, signed range test for overflow
  function automatic logic [34:0] ref_add(input int w, input logic [32:0] a,
                                          input logic [32:0] b, input logic c);
    longint unsigned mask, ua, ub, tot;
    longint sa, sb, st, lim;
    logic [32:0] s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    ua   = {31'd0, a} & mask;
    ub   = {31'd0, b} & mask;
    tot  = ua + ub + {63'd0, c};
    s    = 33'(tot & mask);
    co   = ((tot >> w) & 64'd1) != 64'd0;
    lim  = longint'(1) << (w - 1);
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sa >= lim) sa = sa - 2 * lim;
    if (sb >= lim) sb = sb - 2 * lim;
    st   = sa + sb + longint'({63'd0, c});
    ov   = (st >= lim) || (st < -lim);
    return {ov, co, s};
  endfunction

  logic [32:0] exp_sum  [NI];
  logic        exp_cout [NI];
  logic        exp_ovf  [NI];
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    logic [34:0] r;
    if (rst) model_valid <= 1'b1;
    for (int k = 0; k < NI; k++) begin
      r = ref_add(WIDTHS[k], a_vec, b_vec, cin);
      if (rst) begin
        exp_sum[k]  <= '0;
        exp_cout[k] <= 1'b0;
        exp_ovf[k]  <= 1'b0;
      end else begin
        exp_sum[k]  <= r[32:0];
        exp_cout[k] <= r[33];
        exp_ovf[k]  <= r[34];
      end
    end
  end

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("model_sum_N%0d", WIDTHS[k]), {1'b0, dut_sum[k]}, {1'b0, exp_sum[k]});
        check($sformatf("model_cout_N%0d", WIDTHS[k]), {33'd0, dut_cout[k]}, {33'd0, exp_cout[k]});
`ifdef GEN_CASE_ADD_OVF_EN
        check($sformatf("model_ovf_N%0d", WIDTHS[k]), {33'd0, dut_ovf[k]}, {33'd0, exp_ovf[k]});
`endif
      end
    end
  end

  task automatic drive(input logic [32:0] a, input logic [32:0] b, input logic c, input logic r);
    @(negedge clk);
    a_vec = a;
    b_vec = b;
    cin   = c;
    rst   = r;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%0b a=%0h b=%0h cin=%0b -> N8 sum=%0h cout=%0b",
             $time, r, a, b, c, dut_sum[I_N8], dut_cout[I_N8]);
  endtask

  task automatic lit(input string nm, input int idx, input logic [32:0] s, input logic co);
    check({nm, "_sum"}, {1'b0, dut_sum[idx]}, {1'b0, s});
    check({nm, "_cout"}, {33'd0, dut_cout[idx]}, {33'd0, co});
  endtask

  logic [1:0] n1_table [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    logic [2:0] iv;
    drive(33'd5, 33'd5, 1'b1, 1'b1);
    drive(33'd6, 33'd1, 1'b0, 1'b1);
    lit("reset_N3", I_N3, 33'd0, 1'b0);
    lit("reset_N33", I_N33, 33'd0, 1'b0);

    drive(33'b010, 33'b101, 1'b0, 1'b0);
    lit("n3_010_101", I_N3, 33'b111, 1'b0);

    drive(33'b111, 33'b111, 1'b1, 1'b0);
    lit("n3_wrap", I_N3, 33'b111, 1'b1);
    lit("n8_7_7_1", I_N8, 33'd15, 1'b0);
`ifdef GEN_CASE_ADD_OVF_EN
    check("n3_wrap_ovf", {33'd0, dut_ovf[I_N3]}, 34'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      iv = 3'(i);
      drive({32'd0, iv[2]}, {32'd0, iv[1]}, iv[0], 1'b0);
      check($sformatf("n1_combo_%0d", i), {32'd0, dut_cout[I_N1], dut_sum[I_N1][0]},
            {32'd0, n1_table[i]});
    end

    drive(33'hFF, 33'h01, 1'b0, 1'b0);
    lit("n8_ff_01", I_N8, 33'h00, 1'b1);
    lit("n16_ff_01", I_N16, 33'h100, 1'b0);

    drive(33'h7F, 33'h01, 1'b0, 1'b0);
    lit("n8_7f_01", I_N8, 33'h80, 1'b0);
`ifdef GEN_CASE_ADD_OVF_EN
    check("n8_7f_01_ovf", {33'd0, dut_ovf[I_N8]}, 34'd1);
`endif

    drive('1, '1, 1'b1, 1'b0);
    lit("n33_all_ones", I_N33, 33'h1_FFFF_FFFF, 1'b1);
    lit("n5_all_ones", I_N5, 33'h1F, 1'b1);

    drive(33'd10, 33'd20, 1'b0, 1'b0);
    lit("mid_pre", I_N8, 33'd30, 1'b0);
    drive(33'd99, 33'd99, 1'b1, 1'b1);
    lit("mid_rst", I_N8, 33'd0, 1'b0);
    drive(33'd1, 33'd2, 1'b0, 1'b0);
    lit("mid_post", I_N8, 33'd3, 1'b0);

    for (int i = 0; i < 1000; i++)
      drive({1'($urandom), $urandom}, {1'($urandom), $urandom}, 1'($urandom), 1'b0);

    drive(33'd0, 33'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
